// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : len5_config_pkg / len5_pkg
// Purpose : Shared configuration constants for the LEN5 backend and the
//           Common Data Bus payload type.
//           len5_config_pkg - number of execution units, EU index map and
//                             ROB depth.
//           len5_pkg        - cdb_data_t, the packed payload carried on the
//                             CDB (rob_idx in the MSBs, except_code in the
//                             LSBs).
// Revision: 1.0 - initial release
// ============================================================================
package len5_config_pkg;

    localparam int MAX_EU_N        = 7;
    localparam int ROB_DEPTH       = 32;

    localparam int EU_LOAD_BUFFER  = 0;
    localparam int EU_STORE_BUFFER = 1;
    localparam int EU_BRANCH_UNIT  = 2;
    localparam int EU_INT_ALU      = 3;
    localparam int EU_INT_MULT     = 4;
    localparam int EU_INT_DIV      = 5;
    localparam int EU_FPU          = 6;

endpackage

package len5_pkg;

    import len5_config_pkg::*;

    typedef struct packed {
        logic [$clog2(ROB_DEPTH)-1:0] rob_idx;
        logic [63:0]                  res_value;
        logic                         except_raised;
        logic [4:0]                   except_code;
    } cdb_data_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : rr_prio_enc
// Purpose : Parametric priority encoder with a rotating start index. The
//           request vector is scanned upward from i_start, wrapping modulo N;
//           the first set request wins. Driving i_start with a constant 0
//           turns it into a plain lowest-index-first encoder.
// Ports   : i_req    [N]     request vector
//           i_start  [IDX_W] index where the search begins (must be < N)
//           o_valid          at least one request found
//           o_idx    [IDX_W] index of the winning request (0 if none)
//           o_onehot [N]     one-hot of the winner (0 if none)
// Revision: 1.0 - initial release
// ============================================================================
module rr_prio_enc #(
    parameter int N     = 7,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [N-1:0]     o_onehot
);

    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N);

    // One extra bit so start+offset can exceed N-1 before the wrap.
    logic [IDX_W:0] w_pos;

    always_comb begin
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_pos    = '0;
        for (int off = 0; off < N; off++) begin
            w_pos = {1'b0, i_start} + (IDX_W+1)'(off);
            if (w_pos >= c_n) begin
                w_pos = w_pos - c_n;
            end
            if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
                o_valid                     = 1'b1;
                o_idx                       = w_pos[IDX_W-1:0];
                o_onehot[w_pos[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Purpose : Grants one execution unit per cycle onto the Common Data Bus and
//           registers its result (1-cycle latency, 1 result/cycle sustained).
//           Build option: LEN5_CDB_RR_ARB_EN
//             defined   - round-robin priority from pointer r_rr
//             undefined - fixed priority, lowest index wins (no pointer)
// Ports   : clk_i, rst_i (sync, active-high), flush_i
//           eu_valid_i [EU_N]          per-unit result valid
//           eu_ready_o [EU_N]          per-unit grant (one-hot or zero)
//           eu_data_i  [EU_N*DATA_W]   per-unit payload, unit k at k*DATA_W
//           rob_ready_i                CDB consumer ready
//           cdb_valid_o, cdb_data_o [DATA_W], cdb_src_o [SRC_W]
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import len5_config_pkg::*;
    import len5_pkg::*;
#(
    parameter  int EU_N   = MAX_EU_N,
    parameter  int DATA_W = $bits(cdb_data_t),
    localparam int SRC_W  = (EU_N > 1) ? $clog2(EU_N) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [EU_N-1:0]          eu_valid_i,
    output logic [EU_N-1:0]          eu_ready_o,
    input  logic [EU_N*DATA_W-1:0]   eu_data_i,
    input  logic                     rob_ready_i,
    output logic                     cdb_valid_o,
    output logic [DATA_W-1:0]        cdb_data_o,
    output logic [SRC_W-1:0]         cdb_src_o
);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic [SRC_W-1:0]      r_src;

    logic                  w_can_accept;
    logic                  w_grant_en;
    logic                  w_req_found;
    logic                  w_xfer;
    logic [SRC_W-1:0]      w_start;
    logic [SRC_W-1:0]      w_grant_idx;
    logic [EU_N-1:0]       w_grant_oh;
    logic [DATA_W-1:0]     w_sel_data;

    // The output slot frees up either because it is empty or because the
    // consumer takes the current entry this cycle.
    assign w_can_accept = !r_valid || rob_ready_i;
    assign w_grant_en   = w_can_accept && !flush_i;
    assign w_xfer       = w_grant_en && w_req_found;

    rr_prio_enc #(
        .N     (EU_N),
        .IDX_W (SRC_W)
    ) u_prio_enc (
        .i_req    (eu_valid_i),
        .i_start  (w_start),
        .o_valid  (w_req_found),
        .o_idx    (w_grant_idx),
        .o_onehot (w_grant_oh)
    );

`ifdef LEN5_CDB_RR_ARB_EN
    localparam logic [SRC_W-1:0] c_last_eu = SRC_W'(EU_N - 1);

    logic [SRC_W-1:0] r_rr;

    assign w_start = r_rr;

    // Pointer moves just past the winner; untouched on stall, flush or idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (w_xfer) begin
            r_rr <= (w_grant_idx == c_last_eu) ? '0 : w_grant_idx + 1'b1;
        end
    end
`else
    assign w_start = '0;
`endif

    assign eu_ready_o = w_grant_en ? w_grant_oh : '0;

    // AND-OR mux on the one-hot grant.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < EU_N; k++) begin
            if (w_grant_oh[k]) begin
                w_sel_data = w_sel_data | eu_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_can_accept) begin
            if (w_req_found) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_src   <= w_grant_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign cdb_valid_o = r_valid;
    assign cdb_data_o  = r_data;
    assign cdb_src_o   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Purpose : Self-checking bench for cdb_arbiter. A behavioural model (output
//           slot + search pointer) predicts grants and CDB contents each
//           cycle; directed scenarios add literal expectations, followed by
//           constrained-random traffic. Honours LEN5_CDB_RR_ARB_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int EU_N   = 7;
    localparam int DATA_W = 75;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic [EU_N-1:0]        eu_valid_i;
    logic [EU_N-1:0]        eu_ready_o;
    logic [EU_N*DATA_W-1:0] eu_data_i;
    logic                   rob_ready_i;
    logic                   cdb_valid_o;
    logic [DATA_W-1:0]      cdb_data_o;
    logic [2:0]             cdb_src_o;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .EU_N   (EU_N),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .eu_valid_i  (eu_valid_i),
        .eu_ready_o  (eu_ready_o),
        .eu_data_i   (eu_data_i),
        .rob_ready_i (rob_ready_i),
        .cdb_valid_o (cdb_valid_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_src_o   (cdb_src_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    int                m_src   = 0;
    int                m_rr    = 0;
    logic [EU_N-1:0]   last_grant = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int rob, input logic [63:0] val);
        return {5'(rob), val, 1'b0, 5'd0};
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    task automatic set_unit(input int k, input logic v, input logic [DATA_W-1:0] d);
        eu_valid_i[k] = v;
        eu_data_i[k*DATA_W +: DATA_W] = d;
    endtask

    // Which unit must be granted now: nobody if the slot cannot take a new
    // entry or a flush is in progress, else the first requester found when
    // counting upward from the pointer around the ring of units.
    function automatic logic [EU_N-1:0] model_grant();
        logic [EU_N-1:0] g;
        g = '0;
        if (flush_i || (m_valid && !rob_ready_i)) return g;
        for (int off = 0; off < EU_N; off++) begin
            int k;
            k = (m_rr + off) % EU_N;
            if (eu_valid_i[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, return 1 time unit after it so new stimulus can be driven.
    task automatic cycle();
        logic [EU_N-1:0] g;
        @(negedge clk);
        g = model_grant();
        chk("eu_ready",  128'(eu_ready_o),  128'(g));
        chk("cdb_valid", 128'(cdb_valid_o), 128'(m_valid));
        chk("cdb_data",  128'(cdb_data_o),  128'(m_data));
        chk("cdb_src",   128'(cdb_src_o),   128'(m_src));
        @(posedge clk);
        if (rst_i) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_rr    = 0;
        end else if (flush_i) begin
            m_valid = 1'b0;
        end else if (!m_valid || rob_ready_i) begin
            m_valid = 1'b0;
            for (int k = 0; k < EU_N; k++) begin
                if (g[k]) begin
                    m_valid = 1'b1;
                    m_data  = eu_data_i[k*DATA_W +: DATA_W];
                    m_src   = k;
`ifdef LEN5_CDB_RR_ARB_EN
                    m_rr    = (k + 1) % EU_N;
`endif
                end
            end
        end
        last_grant = rst_i ? '0 : g;
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        logic              prev_rst;

        rst_i       = 1'b1;
        flush_i     = 1'b0;
        rob_ready_i = 1'b0;
        eu_valid_i  = '0;
        eu_data_i   = '0;

        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst_i = 1'b0;

        // Reset state
        chk("rst_valid", 128'(cdb_valid_o), 128'(1'b0));
        chk("rst_data",  128'(cdb_data_o),  128'(0));
        chk("rst_src",   128'(cdb_src_o),   128'(0));
        chk("rst_ready", 128'(eu_ready_o),  128'(0));

        // Single request from the branch unit
        set_unit(2, 1'b1, mk(3, 64'h0123_4567_89AB_CDEF));
        rob_ready_i = 1'b1;
        #1;
        chk("single_ready", 128'(eu_ready_o), 128'(7'b0000100));
        cycle();
        set_unit(2, 1'b0, '0);
        chk("single_valid", 128'(cdb_valid_o), 128'(1'b1));
        chk("single_src",   128'(cdb_src_o),   128'(3'd2));
        chk("single_rob",   128'(cdb_data_o[74:70]), 128'(5'd3));

        // All units requesting continuously from a fresh reset
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        for (int k = 0; k < EU_N; k++) set_unit(k, 1'b1, mk(k + 10, 64'(k)));
        for (int i = 0; i < 8; i++) begin
            cycle();
`ifdef LEN5_CDB_RR_ARB_EN
            chk("stream_src", 128'(cdb_src_o), 128'(i % EU_N));
`else
            chk("stream_src", 128'(cdb_src_o), 128'(0));
`endif
        end

        // Backpressure with unit 5 waiting
        eu_valid_i = '0;
        set_unit(5, 1'b1, mk(21, 64'h55));
        rob_ready_i = 1'b0;
        held = cdb_data_o;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 128'(eu_ready_o), 128'(0));
            cycle();
            chk("bp_hold",  128'(cdb_data_o), 128'(held));
            chk("bp_valid", 128'(cdb_valid_o), 128'(1'b1));
        end
        rob_ready_i = 1'b1;
        #1;
        chk("bp_release", 128'(eu_ready_o), 128'(7'b0100000));
        cycle();
        set_unit(5, 1'b0, '0);
        chk("bp_src", 128'(cdb_src_o), 128'(3'd5));
        chk("bp_rob", 128'(cdb_data_o[74:70]), 128'(5'd21));

        // Flush with unit 1 requesting
        set_unit(1, 1'b1, mk(9, 64'h99));
        flush_i = 1'b1;
        #1;
        chk("flush_ready", 128'(eu_ready_o), 128'(0));
        cycle();
        flush_i = 1'b0;
        chk("flush_valid", 128'(cdb_valid_o), 128'(1'b0));
        #1;
        chk("post_flush_ready", 128'(eu_ready_o), 128'(7'b0000010));
        cycle();
        set_unit(1, 1'b0, '0);
        chk("post_flush_src", 128'(cdb_src_o), 128'(3'd1));

        // Reset mid-stream (pointer sits at 4 after a grant to unit 3)
        set_unit(3, 1'b1, mk(4, 64'h33));
        cycle();
        for (int k = 0; k < EU_N; k++) set_unit(k, 1'b1, mk(k, 64'(k)));
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("mid_rst_valid", 128'(cdb_valid_o), 128'(1'b0));
        chk("mid_rst_data",  128'(cdb_data_o),  128'(0));
        chk("mid_rst_src",   128'(cdb_src_o),   128'(0));
        #1;
        chk("mid_rst_grant", 128'(eu_ready_o), 128'(7'b0000001));
        cycle();
        chk("mid_rst_src0", 128'(cdb_src_o), 128'(0));

        // Random traffic; a unit keeps its request stable until granted
        prev_rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < EU_N; k++) begin
                if (prev_rst || !eu_valid_i[k] || last_grant[k]) begin
                    set_unit(k, ($urandom_range(0, 2) != 0), rnd_data());
                end
            end
            rob_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            rst_i       = ($urandom_range(0, 99) == 0);
            prev_rst    = rst_i;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
